// File: rtl/enemy_fleet_manager.sv
// Frame-rate supervisor for the enemy fleet: wave FSM, per-ship alive mask,
// schedule counter, kill and wave counters, and a round-robin fire arbiter
// that limits how many enemy shots may be granted in one frame.
// Every output comes from a flop; FleetState doubles as the FSM debug view.
module enemy_fleet_manager #(
   parameter int NE          = 8,
   parameter int CTR_W       = 10,
   parameter int SCHED_LEN   = 600,
   parameter int SPAWN_DELAY = 60,
   parameter int MAX_FIRE    = 2,
   parameter int WAVE_W      = 4,
   parameter int KILL_W      = 12
) (
   input  logic              frame_clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              PlayerDead,
   input  logic [NE-1:0]     EShipColl,
   input  logic [NE-1:0]     EFireReq,
   output logic [NE-1:0]     EAlive,
   output logic [NE-1:0]     EFireGnt,
   output logic [CTR_W-1:0]  ESchedCtr,
   output logic [WAVE_W-1:0] WaveNum,
   output logic [KILL_W-1:0] KillCnt,
   output logic              ESpawn,
   output logic              WaveClear,
   output logic [1:0]        FleetState
);

   localparam int DLY_W = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
   localparam int PTR_W = (NE > 1) ? $clog2(NE) : 1;
   localparam int POP_W = $clog2(NE + 1);
   localparam int KS_W  = KILL_W + POP_W;

   localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(SPAWN_DELAY - 1);
   localparam logic [CTR_W-1:0]  SCHED_MAX = CTR_W'(SCHED_LEN - 1);
   localparam logic [KILL_W-1:0] KILL_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SPAWN  = 2'd1,
      ACTIVE = 2'd2,
      CLEAR  = 2'd3
   } fleet_state_t;

   fleet_state_t      state_q, state_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;

   logic [NE-1:0]     alive_d, gnt_d;
   logic [CTR_W-1:0]  ctr_d;
   logic [WAVE_W-1:0] wave_d;
   logic [KILL_W-1:0] kill_d;
   logic              spawn_d, clear_d;

   // Hit / kill bookkeeping signals
   logic [NE-1:0]     hit;
   logic [NE-1:0]     alive_left;
   logic [POP_W-1:0]  hit_cnt;
   logic [KS_W-1:0]   kill_sum;
   logic [KILL_W-1:0] kill_next;

   // Fire arbiter signals
   logic [NE-1:0]     eligible;
   logic [NE-1:0]     gnt_raw;
   logic [PTR_W-1:0]  last_idx;
   logic              any_gnt;
   logic [PTR_W-1:0]  ptr_next;
   logic [PTR_W:0]    idx_w;
   logic [PTR_W-1:0]  idx;
   int                n_gnt;

   assign hit        = EShipColl & EAlive;
   assign alive_left = EAlive & ~hit;
   // A ship hit this frame cannot also fire this frame.
   assign eligible   = EFireReq & EAlive & ~EShipColl;

   // Count ships destroyed this frame and add to the saturating kill total.
   always_comb begin
      hit_cnt = '0;
      for (int k = 0; k < NE; k++) begin
         hit_cnt = hit_cnt + POP_W'(hit[k]);
      end
      kill_sum = KS_W'(KillCnt) + KS_W'(hit_cnt);
      if (kill_sum > KS_W'(KILL_MAX)) begin
         kill_next = KILL_MAX;
      end else begin
         kill_next = kill_sum[KILL_W-1:0];
      end
   end

   // Round-robin scan from ptr_q: grant the first MAX_FIRE eligible ships.
   always_comb begin
      gnt_raw  = '0;
      last_idx = ptr_q;
      any_gnt  = 1'b0;
      n_gnt    = 0;
      idx_w    = '0;
      idx      = '0;
      for (int k = 0; k < NE; k++) begin
         idx_w = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (idx_w >= (PTR_W+1)'(NE)) begin
            idx_w = idx_w - (PTR_W+1)'(NE);
         end
         idx = idx_w[PTR_W-1:0];
         if (eligible[idx] && (n_gnt < MAX_FIRE)) begin
            gnt_raw[idx] = 1'b1;
            n_gnt        = n_gnt + 1;
            last_idx     = idx;
            any_gnt      = 1'b1;
         end
      end
      if (!any_gnt) begin
         ptr_next = ptr_q;
      end else if (last_idx == PTR_W'(NE - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = last_idx + 1'b1;
      end
   end

   // Next-state and next-output logic for the wave FSM.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      ptr_d   = ptr_q;
      alive_d = EAlive;
      gnt_d   = '0;
      ctr_d   = ESchedCtr;
      wave_d  = WaveNum;
      kill_d  = KillCnt;
      spawn_d = 1'b0;
      clear_d = 1'b0;
      if ((state_q != IDLE) && PlayerDead) begin
         // Player death aborts play from any non-idle state; counters persist.
         state_d = IDLE;
         alive_d = '0;
         ctr_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  state_d = SPAWN;
                  dly_d   = DLY_LOAD;
                  wave_d  = '0;
                  kill_d  = '0;
               end
            end
            SPAWN: begin
               if (dly_q == '0) begin
                  state_d = ACTIVE;
                  alive_d = '1;
                  ctr_d   = '0;
                  spawn_d = 1'b1;
               end else begin
                  dly_d = dly_q - 1'b1;
               end
            end
            ACTIVE: begin
               ctr_d   = (ESchedCtr == SCHED_MAX) ? '0 : ESchedCtr + 1'b1;
               alive_d = alive_left;
               kill_d  = kill_next;
               if (alive_left == '0) begin
                  state_d = CLEAR;
                  wave_d  = WaveNum + 1'b1;
                  clear_d = 1'b1;
               end else begin
                  gnt_d = gnt_raw;
                  ptr_d = ptr_next;
               end
            end
            CLEAR: begin
               state_d = SPAWN;
               dly_d   = DLY_LOAD;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers, cleared asynchronously by Reset.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         dly_q     <= '0;
         ptr_q     <= '0;
         EAlive    <= '0;
         EFireGnt  <= '0;
         ESchedCtr <= '0;
         WaveNum   <= '0;
         KillCnt   <= '0;
         ESpawn    <= 1'b0;
         WaveClear <= 1'b0;
      end else begin
         state_q   <= state_d;
         dly_q     <= dly_d;
         ptr_q     <= ptr_d;
         EAlive    <= alive_d;
         EFireGnt  <= gnt_d;
         ESchedCtr <= ctr_d;
         WaveNum   <= wave_d;
         KillCnt   <= kill_d;
         ESpawn    <= spawn_d;
         WaveClear <= clear_d;
      end
   end

   assign FleetState = state_q;

endmodule

// File: tb/tb_enemy_fleet_manager.sv
// Bench for enemy_fleet_manager: directed scenarios plus a randomized run,
// all compared against a frame-level behavioural model of the fleet.
module tb_enemy_fleet_manager;

   localparam int NE          = 4;
   localparam int CTR_W       = 10;
   localparam int SCHED_LEN   = 5;
   localparam int SPAWN_DELAY = 3;
   localparam int MAX_FIRE    = 2;
   localparam int WAVE_W      = 4;
   localparam int KILL_W      = 12;
   localparam int VEC_W       = 2 + NE + NE + CTR_W + WAVE_W + KILL_W + 2;

   logic              frame_clk = 1'b0;
   logic              Reset = 1'b0;
   logic              Start = 1'b0;
   logic              PlayerDead = 1'b0;
   logic [NE-1:0]     EShipColl = '0;
   logic [NE-1:0]     EFireReq = '0;
   logic [NE-1:0]     EAlive, EFireGnt;
   logic [CTR_W-1:0]  ESchedCtr;
   logic [WAVE_W-1:0] WaveNum;
   logic [KILL_W-1:0] KillCnt;
   logic              ESpawn, WaveClear;
   logic [1:0]        FleetState;

   int errors = 0;
   int checks = 0;

   enemy_fleet_manager #(
      .NE(NE), .CTR_W(CTR_W), .SCHED_LEN(SCHED_LEN), .SPAWN_DELAY(SPAWN_DELAY),
      .MAX_FIRE(MAX_FIRE), .WAVE_W(WAVE_W), .KILL_W(KILL_W)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset), .Start(Start), .PlayerDead(PlayerDead),
      .EShipColl(EShipColl), .EFireReq(EFireReq), .EAlive(EAlive), .EFireGnt(EFireGnt),
      .ESchedCtr(ESchedCtr), .WaveNum(WaveNum), .KillCnt(KillCnt), .ESpawn(ESpawn),
      .WaveClear(WaveClear), .FleetState(FleetState)
   );

   // Clock: 10-time-unit frame period.
   always #5 frame_clk = ~frame_clk;

   // ---------------- behavioural model ----------------
   int            m_state;       // 0 idle, 1 spawn, 2 active, 3 clear
   int            m_frames;      // frames already spent in spawn
   int            m_ptr;
   logic [NE-1:0] m_alive, m_gnt;
   int            m_ctr, m_wave, m_kill;
   logic          m_spawn, m_clear;

   logic [VEC_W-1:0] dut_vec;
   assign dut_vec = {FleetState, EAlive, EFireGnt, ESchedCtr, WaveNum, KillCnt, ESpawn, WaveClear};

   function automatic logic [VEC_W-1:0] model_vec();
      return {2'(m_state), m_alive, m_gnt, CTR_W'(m_ctr), WAVE_W'(m_wave),
              KILL_W'(m_kill), m_spawn, m_clear};
   endfunction

   function automatic void model_reset();
      m_state = 0; m_frames = 0; m_ptr = 0; m_alive = '0; m_gnt = '0;
      m_ctr = 0; m_wave = 0; m_kill = 0; m_spawn = 0; m_clear = 0;
   endfunction

   // One frame of fleet behaviour, using the inputs present at the edge.
   function automatic void model_step();
      logic [NE-1:0] hit, elig, old_alive;
      int got, last, i;
      old_alive = m_alive;
      m_spawn = 0; m_clear = 0; m_gnt = '0;
      if (m_state != 0 && PlayerDead) begin
         m_state = 0; m_alive = '0; m_ctr = 0;
         return;
      end
      case (m_state)
         0: if (Start) begin
               m_state = 1; m_frames = 1; m_wave = 0; m_kill = 0;
            end
         1: if (m_frames == SPAWN_DELAY) begin
               m_state = 2; m_alive = '1; m_ctr = 0; m_spawn = 1;
            end else m_frames++;
         2: begin
               hit     = EShipColl & old_alive;
               m_kill  = m_kill + $countones(hit);
               if (m_kill > 4095) m_kill = 4095;
               m_alive = old_alive & ~hit;
               m_ctr   = (m_ctr + 1) % SCHED_LEN;
               if (m_alive == 0) begin
                  m_state = 3; m_wave = (m_wave + 1) % 16; m_clear = 1;
               end else begin
                  elig = EFireReq & old_alive & ~EShipColl;
                  got = 0; last = -1;
                  for (int k = 0; k < NE; k++) begin
                     i = (m_ptr + k) % NE;
                     if (elig[i] && got < MAX_FIRE) begin
                        m_gnt[i] = 1'b1; got++; last = i;
                     end
                  end
                  if (last >= 0) m_ptr = (last + 1) % NE;
               end
            end
         default: begin
               m_state = 1; m_frames = 1;
            end
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge frame_clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      @(negedge frame_clk);
      Reset = 1'b1; Start = 0; PlayerDead = 0; EShipColl = '0; EFireReq = '0;
      model_reset();
      @(negedge frame_clk);
      Reset = 1'b0;
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++; $display("FAIL reset_state: got %h exp %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_spawn_and_sched();
      Start = 1'b1;
      for (int f = 1; f <= SPAWN_DELAY; f++) begin
         tick();
         Start = 1'b0;
         checks++;
         if (FleetState !== 2'd1) begin
            errors++; $display("FAIL spawn_frame%0d: state got %0d exp 1", f, FleetState);
         end
      end
      tick();
      checks++;
      if ({FleetState, EAlive, ESpawn, ESchedCtr} !== {2'd2, 4'b1111, 1'b1, 10'd0}) begin
         errors++; $display("FAIL first_active: got st=%0d alive=%b spawn=%b ctr=%0d exp 2/1111/1/0",
                            FleetState, EAlive, ESpawn, ESchedCtr);
      end
      for (int f = 1; f <= 5; f++) begin
         tick();
         checks++;
         if (ESchedCtr !== CTR_W'(f % SCHED_LEN) || ESpawn !== 1'b0) begin
            errors++; $display("FAIL sched_seq%0d: ctr=%0d spawn=%b exp ctr=%0d spawn=0",
                               f, ESchedCtr, ESpawn, f % SCHED_LEN);
         end
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL sched_model%0d: got %h exp %h", f, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_kills();
      EShipColl = 4'b0101; tick();
      EShipColl = 4'b0101; tick();
      EShipColl = '0;
      checks++;
      if (EAlive !== 4'b1010 || KillCnt !== 12'd2) begin
         errors++; $display("FAIL kill_once: alive=%b kills=%0d exp 1010/2", EAlive, KillCnt);
      end
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++; $display("FAIL kill_model: got %h exp %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_wave_clear();
      EShipColl = 4'b1010; tick();
      EShipColl = '0;
      checks++;
      if ({FleetState, WaveClear, WaveNum, EAlive} !== {2'd3, 1'b1, 4'd1, 4'b0000}) begin
         errors++; $display("FAIL clear_frame: st=%0d clr=%b wave=%0d alive=%b exp 3/1/1/0000",
                            FleetState, WaveClear, WaveNum, EAlive);
      end
      tick();
      checks++;
      if (FleetState !== 2'd1 || WaveClear !== 1'b0) begin
         errors++; $display("FAIL after_clear: st=%0d clr=%b exp 1/0", FleetState, WaveClear);
      end
   endtask

   task automatic test_fire();
      logic [NE-1:0] exp_g[4];
      logic [NE-1:0] req[4];
      int budget = 10;
      exp_g = '{4'b0011, 4'b1100, 4'b0011, 4'b0100};
      req   = '{4'b1111, 4'b1111, 4'b1111, 4'b0100};
      while (FleetState != 2'd2 && budget > 0) begin
         tick(); budget--;
      end
      checks++;
      if (FleetState !== 2'd2) begin
         errors++; $display("FAIL fire_wait_active: st=%0d exp 2", FleetState);
      end
      for (int s = 0; s < 4; s++) begin
         EFireReq = req[s]; tick();
         checks++;
         if (EFireGnt !== exp_g[s]) begin
            errors++; $display("FAIL fire_grant%0d: got %b exp %b", s, EFireGnt, exp_g[s]);
         end
      end
      EFireReq = '0; tick();
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++; $display("FAIL fire_model: got %h exp %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_player_dead();
      PlayerDead = 1'b1; tick();
      PlayerDead = 1'b0;
      checks++;
      if ({FleetState, ESchedCtr, EAlive, KillCnt, WaveNum} !== {2'd0, 10'd0, 4'b0, 12'd4, 4'd1}) begin
         errors++; $display("FAIL player_dead: st=%0d ctr=%0d alive=%b kills=%0d wave=%0d exp 0/0/0000/4/1",
                            FleetState, ESchedCtr, EAlive, KillCnt, WaveNum);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         Start      = ($urandom_range(0, 3) == 0);
         PlayerDead = ($urandom_range(0, 59) == 0);
         EShipColl  = ($urandom_range(0, 5) == 0) ? NE'($urandom) : '0;
         EFireReq   = NE'($urandom);
         tick();
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL random_cycle%0d: got %h exp %h", c, dut_vec, model_vec());
         end
      end
      Start = 0; PlayerDead = 0; EShipColl = '0; EFireReq = '0;
   endtask

   task automatic test_async_reset();
      int budget = 20;
      Start = 1'b1;
      while (FleetState != 2'd2 && budget > 0) begin
         tick(); Start = 1'b0; budget--;
      end
      Start = 1'b0;
      EFireReq = 4'b1111; tick(); tick();
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (dut_vec !== '0) begin
         errors++; $display("FAIL async_reset: got %h exp 0", dut_vec);
      end
      model_reset();
      EFireReq = '0;
      @(negedge frame_clk);
      Reset = 1'b0;
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++; $display("FAIL post_reset_idle: got %h exp %h", dut_vec, model_vec());
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_spawn_and_sched();
      test_kills();
      test_wave_clear();
      test_fire();
      test_player_dead();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
